// File: rtl/w80386dx_bus_pkg.sv
// Shared types and helpers for the i386-style bus cycle unit.
package w80386dx_bus_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BUS_ADDR_W = 30;
  localparam int unsigned BE_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_T1B,
    ST_T2B,
    ST_RESP
  } bus_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_WORD  = 2'b01,
    SZ_DWORD = 2'b10,
    SZ_RSVD  = 2'b11
  } acc_size_e;

  typedef logic [BE_W-1:0] be_n_t;

  // Number of bytes moved by an access; the reserved encoding behaves as a dword.
  function automatic logic [2:0] size_bytes(input acc_size_e size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_WORD: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // LSB-aligned mask keeping only the bytes that belong to the access.
  function automatic logic [DATA_W-1:0] size_mask(input acc_size_e size);
    case (size)
      SZ_BYTE: return 32'h0000_00FF;
      SZ_WORD: return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/byte_enable_generate.sv
// Byte-lane decode: {offset, size} -> active-low byte enables for both halves
// of an access, plus whether the access crosses a dword boundary.
module byte_enable_generate
  import w80386dx_bus_pkg::*;
(
  input  logic [1:0] off_i,
  input  acc_size_e  size_i,
  output be_n_t      be_lo_n_o,
  output be_n_t      be_hi_n_o,
  output logic       split_o
);

  logic [3:0] end_c;

  // Lanes off..end-1 belong to the first dword, lanes beyond 4 spill into the second.
  always_comb begin
    end_c     = 4'(off_i) + 4'(size_bytes(size_i));
    be_lo_n_o = '1;
    be_hi_n_o = '1;
    for (int i = 0; i < 4; i++) begin
      if ((4'(i) >= 4'(off_i)) && (4'(i) < end_c)) be_lo_n_o[i] = 1'b0;
      if (4'(i + 4) < end_c) be_hi_n_o[i] = 1'b0;
    end
    split_o = (end_c > 4'd4);
  end

endmodule

// File: rtl/bus_cycle_unit.sv
// i386-style bus cycle engine: accepts one physical access at a time, runs
// T1/T2 cycles (split into two when crossing a dword), returns read data.
// Optional wait-state timeout abort is enabled by defining BUS_TIMEOUT_EN.
module bus_cycle_unit
  import w80386dx_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_address,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_fault,
  output logic [BUS_ADDR_W-1:0] bus_address,
  output logic [BE_W-1:0]       bus_be_n,
  output logic                  bus_ads_n,
  output logic                  bus_wr_n,
  output logic [DATA_W-1:0]     bus_data_out,
  output logic                  bus_data_oe,
  input  logic [DATA_W-1:0]     bus_data_in,
  input  logic                  bus_ready_n
);

  bus_state_e              state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_fault_q, rsp_fault_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic [BUS_ADDR_W-1:0]   bus_address_q, bus_address_d;
  be_n_t                   bus_be_n_q, bus_be_n_d;
  logic                    bus_ads_n_q, bus_ads_n_d;
  logic                    bus_wr_n_q, bus_wr_n_d;
  logic [DATA_W-1:0]       bus_data_out_q, bus_data_out_d;
  logic                    bus_data_oe_q, bus_data_oe_d;

  logic [1:0]              off_q, off_d;
  acc_size_e               size_q, size_d;
  logic                    write_q, write_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    split_q, split_d;
  be_n_t                   be_hi_n_q, be_hi_n_d;
  logic [DATA_W-1:0]       lo_data_q, lo_data_d;

  be_n_t                   be_lo_n_c, be_hi_n_c;
  logic                    split_c;
  logic [5:0]              hi_shift_c;

  // Lane decode of the incoming request, used at accept time.
  byte_enable_generate u_be_gen (
    .off_i     (req_address[1:0]),
    .size_i    (acc_size_e'(req_size)),
    .be_lo_n_o (be_lo_n_c),
    .be_hi_n_o (be_hi_n_c),
    .split_o   (split_c)
  );

  // Shift that moves the upper part of a split access to/from lane 0.
  assign hi_shift_c = 6'd32 - {1'b0, off_q, 3'b000};

  // Realign the two captured dwords into an LSB-aligned result of the access size.
  function automatic logic [DATA_W-1:0] assemble(input logic [DATA_W-1:0] lo,
                                                 input logic [DATA_W-1:0] hi,
                                                 input logic [1:0]        off,
                                                 input acc_size_e         size);
    logic [5:0] sh_lo;
    logic [5:0] sh_hi;
    sh_lo = {1'b0, off, 3'b000};
    sh_hi = 6'd32 - sh_lo;
    return ((lo >> sh_lo) | (hi << sh_hi)) & size_mask(size);
  endfunction

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_c;

  // Last permitted wait state: the next one aborts the access.
  assign timeout_c = bus_ready_n && (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  // Wait-state counter: cleared in T1 so it starts at zero in each T2.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_q == ST_T1) || (state_q == ST_T1B)) begin
      wait_cnt_d = '0;
    end else if (((state_q == ST_T2) || (state_q == ST_T2B)) && bus_ready_n) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  // Wait-state counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

  // Next-state and registered-output decode for the bus cycle sequence.
  always_comb begin
    state_d        = state_q;
    req_ready_d    = 1'b0;
    rsp_valid_d    = 1'b0;
    rsp_fault_d    = 1'b0;
    rsp_rdata_d    = '0;
    bus_ads_n_d    = 1'b1;
    bus_be_n_d     = bus_be_n_q;
    bus_address_d  = bus_address_q;
    bus_wr_n_d     = bus_wr_n_q;
    bus_data_out_d = bus_data_out_q;
    bus_data_oe_d  = bus_data_oe_q;
    off_d          = off_q;
    size_d         = size_q;
    write_d        = write_q;
    wdata_d        = wdata_q;
    split_d        = split_q;
    be_hi_n_d      = be_hi_n_q;
    lo_data_d      = lo_data_q;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_d   = 1'b1;
        bus_be_n_d    = '1;
        bus_data_oe_d = 1'b0;
        if (req_valid && req_ready_q) begin
          off_d          = req_address[1:0];
          size_d         = acc_size_e'(req_size);
          write_d        = req_write;
          wdata_d        = req_wdata;
          split_d        = split_c;
          be_hi_n_d      = be_hi_n_c;
          req_ready_d    = 1'b0;
          state_d        = ST_T1;
          bus_ads_n_d    = 1'b0;
          bus_address_d  = req_address[ADDR_W-1:2];
          bus_be_n_d     = be_lo_n_c;
          bus_wr_n_d     = req_write;
          bus_data_out_d = req_wdata << {req_address[1:0], 3'b000};
          bus_data_oe_d  = req_write;
        end
      end
      ST_T1:  state_d = ST_T2;
      ST_T1B: state_d = ST_T2B;
      ST_T2, ST_T2B: begin
        if (!bus_ready_n) begin
          lo_data_d = bus_data_in;
          if ((state_q == ST_T2) && split_q) begin
            state_d        = ST_T1B;
            bus_ads_n_d    = 1'b0;
            bus_address_d  = bus_address_q + BUS_ADDR_W'(1);
            bus_be_n_d     = be_hi_n_q;
            bus_data_out_d = wdata_q >> hi_shift_c;
          end else begin
            state_d       = ST_RESP;
            rsp_valid_d   = 1'b1;
            bus_be_n_d    = '1;
            bus_data_oe_d = 1'b0;
            if (!write_q) begin
              rsp_rdata_d = (state_q == ST_T2) ? assemble(bus_data_in, '0, off_q, size_q)
                                               : assemble(lo_data_q, bus_data_in, off_q, size_q);
            end
          end
        end
`ifdef BUS_TIMEOUT_EN
        else if (timeout_c) begin
          state_d       = ST_RESP;
          rsp_valid_d   = 1'b1;
          rsp_fault_d   = 1'b1;
          bus_be_n_d    = '1;
          bus_data_oe_d = 1'b0;
        end
`endif
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, output and request-latch registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_fault_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      bus_address_q  <= '0;
      bus_be_n_q     <= '1;
      bus_ads_n_q    <= 1'b1;
      bus_wr_n_q     <= 1'b0;
      bus_data_out_q <= '0;
      bus_data_oe_q  <= 1'b0;
      off_q          <= '0;
      size_q         <= SZ_BYTE;
      write_q        <= 1'b0;
      wdata_q        <= '0;
      split_q        <= 1'b0;
      be_hi_n_q      <= '1;
      lo_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_fault_q    <= rsp_fault_d;
      rsp_rdata_q    <= rsp_rdata_d;
      bus_address_q  <= bus_address_d;
      bus_be_n_q     <= bus_be_n_d;
      bus_ads_n_q    <= bus_ads_n_d;
      bus_wr_n_q     <= bus_wr_n_d;
      bus_data_out_q <= bus_data_out_d;
      bus_data_oe_q  <= bus_data_oe_d;
      off_q          <= off_d;
      size_q         <= size_d;
      write_q        <= write_d;
      wdata_q        <= wdata_d;
      split_q        <= split_d;
      be_hi_n_q      <= be_hi_n_d;
      lo_data_q      <= lo_data_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_fault    = rsp_fault_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign bus_address  = bus_address_q;
  assign bus_be_n     = bus_be_n_q;
  assign bus_ads_n    = bus_ads_n_q;
  assign bus_wr_n     = bus_wr_n_q;
  assign bus_data_out = bus_data_out_q;
  assign bus_data_oe  = bus_data_oe_q;

endmodule
